// File: rtl/reg_hazard_ctrl.sv
// rtl/reg_hazard_ctrl.sv - register-file RAW hazard controller with shift-register scoreboard
module reg_hazard_ctrl #(
    parameter int DEPTH = 3,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [2:0]      id_rs_sel,
    input  logic            id_rs_used,
    input  logic [2:0]      id_rt_sel,
    input  logic            id_rt_used,
    input  logic            id_wr_en,
    input  logic [2:0]      id_wr_sel,
    input  logic            flush,
    input  logic            hold,
    output logic            stall,
    output logic            issue,
    output logic [7:0]      wr_pending,
    output logic [CNTW-1:0] stall_count,
    output logic            state
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t          cur_state;
    state_t          nxt_state;
    logic [DEPTH-1:0] slot_v;
    logic [2:0]       slot_sel [DEPTH];
    logic             rs_hit;
    logic             rt_hit;
    logic             hz;

    // The WB slot (DEPTH-1) is excluded: the register file forwards its write to same-cycle reads.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (slot_v[k] && (slot_sel[k] == id_rs_sel)) rs_hit = 1'b1;
            if (slot_v[k] && (slot_sel[k] == id_rt_sel)) rt_hit = 1'b1;
        end
    end

    always_comb begin
        wr_pending = 8'h00;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_v[k]) wr_pending[slot_sel[k]] = 1'b1;
        end
    end

    assign hz    = id_valid & ((id_rs_used & rs_hit) | (id_rt_used & rt_hit));
    assign stall = hz & ~flush;
    assign issue = id_valid & ~hz & ~flush & ~hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_v <= '0;
            for (int k = 0; k < DEPTH; k++) slot_sel[k] <= 3'd0;
        end else if (!hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                slot_v[k]   <= slot_v[k-1];
                slot_sel[k] <= slot_sel[k-1];
            end
            // Non-issuing cycles and non-writing instructions both enter EX as v=0.
            slot_v[0]   <= issue & id_wr_en;
            slot_sel[0] <= issue ? id_wr_sel : 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stall && !hold && (stall_count != {CNTW{1'b1}})) begin
            stall_count <= stall_count + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur_state <= RUN;
        else      cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            RUN:     if (stall && !hold)  nxt_state = STALL;
            STALL:   if (!stall && !hold) nxt_state = RUN;
            default: nxt_state = RUN;
        endcase
    end

    assign state = (cur_state == STALL);

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// tb/tb_reg_hazard_ctrl.sv - directed self-checking bench for reg_hazard_ctrl
module tb_reg_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_rs_sel;
    logic        id_rs_used;
    logic [2:0]  id_rt_sel;
    logic        id_rt_used;
    logic        id_wr_en;
    logic [2:0]  id_wr_sel;
    logic        flush;
    logic        hold;
    logic        stall;
    logic        issue;
    logic [7:0]  wr_pending;
    logic [15:0] stall_count;
    logic        state;
    logic        s_stall;
    logic        s_issue;
    logic [7:0]  s_wr_pending;
    logic [3:0]  s_stall_count;
    logic        s_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_hazard_ctrl #(.DEPTH(3), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_sel(id_rs_sel), .id_rs_used(id_rs_used),
        .id_rt_sel(id_rt_sel), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_wr_sel(id_wr_sel),
        .flush(flush), .hold(hold),
        .stall(stall), .issue(issue), .wr_pending(wr_pending),
        .stall_count(stall_count), .state(state)
    );

    // Narrow counter copy sharing all inputs, used for saturation.
    reg_hazard_ctrl #(.DEPTH(3), .CNTW(4)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_sel(id_rs_sel), .id_rs_used(id_rs_used),
        .id_rt_sel(id_rt_sel), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_wr_sel(id_wr_sel),
        .flush(flush), .hold(hold),
        .stall(s_stall), .issue(s_issue), .wr_pending(s_wr_pending),
        .stall_count(s_stall_count), .state(s_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rt, input logic rtu, input logic we,
                       input logic [2:0] ws, input logic fl, input logic hd);
        id_valid   = v;
        id_rs_sel  = rs;
        id_rs_used = rsu;
        id_rt_sel  = rt;
        id_rt_used = rtu;
        id_wr_en   = we;
        id_wr_sel  = ws;
        flush      = fl;
        hold       = hd;
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_issue", issue, 0);
        chk("rst_wrp", wr_pending, 8'h00);
        chk("rst_cnt", stall_count, 0);
        chk("rst_state", state, 0);
        rst = 1'b1;

        // distance-1 RAW on R3 via rs
        tick(); drv(1, 0, 0, 0, 0, 1, 3, 0, 0);
        chk("d1_prod_issue", issue, 1);
        chk("d1_prod_stall", stall, 0);
        tick(); drv(1, 3, 1, 0, 0, 1, 4, 0, 0);
        chk("d1_c1_stall", stall, 1);
        chk("d1_c1_issue", issue, 0);
        chk("d1_c1_wrp", wr_pending, 8'h08);
        chk("d1_c1_state", state, 0);
        tick(); #1;
        chk("d1_c2_stall", stall, 1);
        chk("d1_c2_wrp", wr_pending, 8'h08);
        chk("d1_c2_state", state, 1);
        tick(); #1;
        chk("d1_c3_stall", stall, 0);
        chk("d1_c3_issue", issue, 1);
        chk("d1_c3_wrp", wr_pending, 8'h08);
        chk("d1_c3_cnt", stall_count, 2);
        tick(); idle();
        chk("d1_c4_wrp", wr_pending, 8'h10);
        chk("d1_c4_state", state, 0);
        repeat (3) tick();
        chk("d1_drain_wrp", wr_pending, 8'h00);

        // distance-2 RAW on R5 via rt
        tick(); drv(1, 0, 0, 0, 0, 1, 5, 0, 0);
        tick(); drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("d2_nop_issue", issue, 1);
        tick(); drv(1, 0, 0, 5, 1, 0, 0, 0, 0);
        chk("d2_stall", stall, 1);
        chk("d2_wrp", wr_pending, 8'h20);
        tick(); #1;
        chk("d2_after_stall", stall, 0);
        chk("d2_after_issue", issue, 1);
        tick(); idle();
        chk("d2_cnt", stall_count, 3);
        chk("d2_wrp_clear", wr_pending, 8'h00);

        // distance-3 on R5 via rt: no stall
        tick(); drv(1, 0, 0, 0, 0, 1, 5, 0, 0);
        tick(); drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); drv(1, 0, 0, 5, 1, 0, 0, 0, 0);
        chk("d3_stall", stall, 0);
        chk("d3_issue", issue, 1);
        chk("d3_wrp", wr_pending, 8'h20);
        tick(); idle();
        repeat (3) tick();

        // hold while stalled on R2
        tick(); drv(1, 0, 0, 0, 0, 1, 2, 0, 0);
        tick(); drv(1, 2, 1, 0, 0, 0, 0, 0, 1);
        chk("hold_stall", stall, 1);
        chk("hold_issue", issue, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("hold_stall_held", stall, 1);
        end
        chk("hold_cnt", stall_count, 3);
        chk("hold_wrp", wr_pending, 8'h04);
        chk("hold_state", state, 0);
        drv(1, 2, 1, 0, 0, 0, 0, 0, 0);
        chk("hold_rel_stall", stall, 1);
        tick(); #1;
        chk("hold_rel2_stall", stall, 1);
        chk("hold_rel2_state", state, 1);
        chk("hold_rel2_cnt", stall_count, 4);
        tick(); #1;
        chk("hold_done_stall", stall, 0);
        chk("hold_done_issue", issue, 1);
        chk("hold_done_cnt", stall_count, 5);
        tick(); idle();
        repeat (3) tick();

        // flush on a hazarding instruction
        tick(); drv(1, 0, 0, 0, 0, 1, 1, 0, 0);
        tick(); drv(1, 1, 1, 0, 0, 1, 6, 1, 0);
        chk("flush_stall", stall, 0);
        chk("flush_issue", issue, 0);
        tick(); idle();
        chk("flush_wrp", wr_pending, 8'h02);
        chk("flush_state", state, 0);
        chk("flush_cnt", stall_count, 5);
        repeat (3) tick();

        // link register R7
        tick(); drv(1, 0, 0, 0, 0, 1, 7, 0, 0);
        tick(); drv(1, 0, 0, 7, 1, 0, 0, 0, 0);
        chk("r7_stall", stall, 1);
        tick(); #1;
        tick(); #1;
        chk("r7_issue", issue, 1);
        chk("r7_cnt", stall_count, 7);
        tick(); idle();

        // unused source reading a pending register
        tick(); drv(1, 0, 0, 0, 0, 1, 3, 0, 0);
        tick(); drv(1, 3, 0, 3, 0, 0, 0, 0, 0);
        chk("nouse_stall", stall, 0);
        chk("nouse_issue", issue, 1);
        chk("nouse_wrp", wr_pending, 8'h08);
        tick(); idle();
        repeat (3) tick();

        // chained R0 read/write: issue, stall, stall repeating -> 20 stalls in 30 cycles
        tick(); drv(1, 0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            if (i > 0) begin
                tick(); #1;
            end
            chk("chain_stall", stall, (i % 3) != 0);
        end
        tick(); idle();
        chk("sat_main_cnt", stall_count, 27);
        chk("sat_cnt", s_stall_count, 4'hf);
        repeat (3) tick();

        // async reset while stalled with slots populated
        tick(); drv(1, 0, 0, 0, 0, 1, 4, 0, 0);
        tick(); drv(1, 4, 1, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_stall", stall, 1);
        tick(); #1;
        chk("pre_rst_state", state, 1);
        chk("pre_rst_wrp", wr_pending, 8'h10);
        #2;
        idle();
        rst = 1'b0;
        #1;
        chk("mid_rst_wrp", wr_pending, 8'h00);
        chk("mid_rst_cnt", stall_count, 0);
        chk("mid_rst_sat_cnt", s_stall_count, 0);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_issue", issue, 0);
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_hazard_ctrl.md
Name: reg_hazard_ctrl

Overview:
- Register-file hazard controller for the 16-bit pipeline. It sits beside decode and the 8x16 register file (write-before-read bypass).
- It tracks destination registers of in-flight instructions in a shift-register scoreboard and stalls decode on read-after-write conflicts.
- It inserts bubbles, handles flush and memory hold, and counts stall cycles.

Parameters:
- DEPTH, 3, number of post-decode stages (EX..WB). Slot DEPTH-1 is WB, which writes the register file this cycle.
- CNTW, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- id_valid  in  1  decode holds a valid instruction
- id_rs_sel  in  3  first read register (Instr[10:8])
- id_rs_used  in  1  instruction reads id_rs_sel
- id_rt_sel  in  3  second read register (Instr[7:5])
- id_rt_used  in  1  instruction reads id_rt_sel
- id_wr_en  in  1  instruction writes a register
- id_wr_sel  in  3  write register, already resolved by RegDst (R7 for link)
- flush  in  1  squash the instruction currently in decode
- hold  in  1  whole pipeline frozen (memory stall)
- stall  out  1  decode/fetch must hold this cycle
- issue  out  1  instruction leaves decode into EX this cycle
- wr_pending  out  8  bit r set if any valid slot 0..DEPTH-1 targets register r
- stall_count  out  CNTW  saturating count of hazard-stall cycles
- state  out  1  0 = RUN, 1 = STALL

Behaviour:
- Storage: DEPTH slots {v, sel[2:0]}. Slot 0 = EX.
- Reset (rst=0, async): all slots v=0; stall_count=0; state=RUN. Outputs then read stall=0, issue=0, wr_pending=0.
- Hazard (combinational): hz = id_valid & ((id_rs_used & match(id_rs_sel)) | (id_rt_used & match(id_rt_sel))).
  - match(r) = any slot k in 0..DEPTH-2 with v=1 and sel=r.
  - Slot DEPTH-1 is never checked; the register file bypass covers it.
- stall = hz & ~flush (combinational, same cycle).
- issue = id_valid & ~hz & ~flush & ~hold.
- Slot update, rising clk:
  - hold=1: all slots, state and stall_count unchanged. hold has priority over flush; flush must stay asserted until hold drops.
  - hold=0: slot[k] <= slot[k-1] for k>=1. slot[0] <= issue ? {id_wr_en, id_wr_sel} : {0, xxx} (bubble).
  - Instructions with id_wr_en=0 occupy a slot with v=0.
- FSM:
  - RUN -> STALL when stall=1 & hold=0.
  - STALL -> RUN when stall=0 & hold=0.
  - Otherwise unchanged.
- stall_count: +1 each clk with stall=1 & hold=0. It saturates at all-ones and never wraps.
- Latency: with DEPTH=3, a dependent instruction stalls 2 cycles at distance 1, 1 cycle at distance 2, and 0 at distance >=3.
- Simultaneous events:
  - flush with hazard: no stall, no issue, bubble inserted.
  - Both sources hit different slots: stall persists until the youngest producer passes slot DEPTH-2.
  - Same register written by two in-flight slots: wr_pending bit stays set until both leave.
- An instruction reading the register it writes follows the same hazard rule; its own dest is not yet in a slot.
- Reset mid-operation clears all slots. Pending writes are dropped from tracking immediately.
- id_*_sel values are don't-care when the corresponding used/valid bit is 0.

Test Plan:
- Reset: rst=0 with slots populated -> next sample all slots clear, wr_pending=0x00, stall_count=0, state=RUN.
- Distance-1 RAW: issue write R3; next cycle decode reads R3 as rs -> stall=1 for exactly 2 cycles, then issue=1. stall_count=2, wr_pending bit3 set for 3 cycles.
- Distance-2 and distance-3 RAW on R5 via rt -> 1 stall cycle, then 0 stall cycles.
- Hold during stall: producer in slot0, hold=1 for 4 cycles -> slots frozen, stall stays 1, stall_count does not increment. After hold drops -> 2 counted stall cycles total.
- Flush on a hazarding instruction: flush=1 while rs matches slot0 -> stall=0, issue=0, slot0 becomes bubble, state=RUN.
- Saturation and non-hazards:
  - With CNTW=4, force 20 stall cycles -> stall_count=15.
  - A write to R7 (link) followed by a read of R7 stalls.
  - An instruction with id_rs_used=0 reading a pending register issues without stall.
